// File: rtl/serial_parity_framer_pkg.sv
// Shared types and constants for the serial parity framer.
package serial_parity_framer_pkg;

  // Output register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // Parity-mode selectors.
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Parity of a completed frame: running XOR of the earlier bits, the
  // final bit, and the mode bit (odd mode inverts the even result).
  function automatic logic frame_parity(logic run_par, logic last_bit, logic mode);
    return run_par ^ last_bit ^ mode;
  endfunction

endpackage

// File: rtl/serial_parity_framer_if.sv
// Serial-in / frame-out handshake bundle.
// master: the environment (drives upstream bits, consumes frames).
// slave : the framer itself.
interface serial_parity_framer_if #(
  parameter int DATA_W = 8
) ();

  logic              up_valid;
  logic              up_data;
  logic              up_ready;
  logic              down_valid;
  logic [DATA_W-1:0] down_data;
  logic              down_parity;
  logic              down_ready;

  modport master (
    output up_valid, up_data, down_ready,
    input  up_ready, down_valid, down_data, down_parity
  );

  modport slave (
    input  up_valid, up_data, down_ready,
    output up_ready, down_valid, down_data, down_parity
  );

endinterface

// File: rtl/serial_parity_framer_accum.sv
// Collect side of the framer: stores the first DATA_W-1 bits of a frame,
// counts accepted bits and keeps the running parity. The final bit of a
// frame is never stored here; the top level takes it straight from the
// input when it loads the output register.
module serial_parity_accum #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              bit_in,
  output logic [DATA_W-2:0] acc,
  output logic              par,
  output logic              last
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             par_reg;

  assign last = (cnt_reg == CNT_LAST);
  assign par  = par_reg;

  // Bit counter and running parity; both restart when a frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      par_reg <= 1'b0;
    end else if (accept) begin
      if (last) begin
        cnt_reg <= '0;
        par_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
        par_reg <= par_reg ^ bit_in;
      end
    end
  end

  // One storage flop per frame position, written when the counter points at it.
  generate
    for (genvar gi = 0; gi < DATA_W - 1; gi++) begin : g_acc
      logic bit_reg;

      // Capture the incoming bit into its position in the frame.
      always_ff @(posedge clk) begin
        if (rst) begin
          bit_reg <= 1'b0;
        end else if (accept && (cnt_reg == CNT_W'(gi))) begin
          bit_reg <= bit_in;
        end
      end

      assign acc[gi] = bit_reg;
    end
  endgenerate

endmodule

// File: rtl/serial_parity_framer.sv
// Serial-to-parallel framer with parity. Bits arrive one per transfer,
// LSB of the frame first; each completed frame is held in a one-deep
// output register behind a valid/ready handshake. Only the completing bit
// is ever stalled, so serial input keeps flowing while a frame waits.
module serial_parity_framer #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = serial_parity_framer_pkg::PARITY_EVEN
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_parity_framer_if.slave  bus
);

  import serial_parity_framer_pkg::*;

  logic [DATA_W-2:0] acc;
  logic              par;
  logic              last;
  logic              accept;
  logic              complete;

  out_state_t        state_reg;
  logic [DATA_W-1:0] data_reg;
  logic              parity_reg;

  // The completing bit may only enter when the output slot is free or is
  // being drained this very cycle.
  assign bus.up_ready    = !last || (state_reg == EMPTY) || bus.down_ready;
  assign accept          = bus.up_valid && bus.up_ready;
  assign complete        = accept && last;

  assign bus.down_valid  = (state_reg == FULL);
  assign bus.down_data   = data_reg;
  assign bus.down_parity = parity_reg;

  serial_parity_accum #(
    .DATA_W (DATA_W)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .accept (accept),
    .bit_in (bus.up_data),
    .acc    (acc),
    .par    (par),
    .last   (last)
  );

  // Output slot FSM: load on completion (replacing a frame drained in the
  // same cycle), empty on a drain without a concurrent completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= EMPTY;
      data_reg   <= '0;
      parity_reg <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (complete) begin
            state_reg  <= FULL;
            data_reg   <= {bus.up_data, acc};
            parity_reg <= frame_parity(par, bus.up_data, PARITY_ODD);
          end
        end
        FULL: begin
          if (complete) begin
            state_reg  <= FULL;
            data_reg   <= {bus.up_data, acc};
            parity_reg <= frame_parity(par, bus.up_data, PARITY_ODD);
          end else if (bus.down_ready) begin
            state_reg  <= EMPTY;
          end
        end
        default: begin
          state_reg <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_framer.sv
// Bench for serial_parity_framer: an even-parity and an odd-parity instance
// share identical stimulus. A bit-list reference model predicts every cycle;
// a table of known frames and hand-written sequences cover the corner cases.
module tb_serial_parity_framer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_parity_framer_if #(.DATA_W(W)) ev_if ();
  serial_parity_framer_if #(.DATA_W(W)) od_if ();

  serial_parity_framer #(
    .DATA_W     (W),
    .PARITY_ODD (serial_parity_framer_pkg::PARITY_EVEN)
  ) dut_even (
    .clk (clk),
    .rst (rst),
    .bus (ev_if)
  );

  serial_parity_framer #(
    .DATA_W     (W),
    .PARITY_ODD (serial_parity_framer_pkg::PARITY_ODD)
  ) dut_odd (
    .clk (clk),
    .rst (rst),
    .bus (od_if)
  );

  int errors = 0;
  int checks = 0;
  int frames = 0;

  // Reference model: bits of the frame in progress, plus the held frame.
  bit         mq[$];
  bit         m_valid;
  logic [7:0] m_data;

  typedef struct {
    logic [7:0] frame;
    logic [7:0] exp_data;
    bit         exp_even;
    bit         exp_odd;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit v, bit d, bit r);
    ev_if.up_valid   = v;
    ev_if.up_data    = d;
    ev_if.down_ready = r;
    od_if.up_valid   = v;
    od_if.up_data    = d;
    od_if.down_ready = r;
  endtask

  function automatic bit even_par(logic [7:0] f);
    return bit'($countones(f) % 2);
  endfunction

  // One clock: drive inputs, compare both DUTs to the model, advance model.
  task automatic cycle(bit v, bit d, bit r);
    bit m_ready;
    drive(v, d, r);
    #1;
    m_ready = !((mq.size() == W - 1) && m_valid && !r);
    chk("up_ready_even", ev_if.up_ready, m_ready);
    chk("up_ready_odd", od_if.up_ready, m_ready);
    chk("down_valid_even", ev_if.down_valid, m_valid);
    chk("down_valid_odd", od_if.down_valid, m_valid);
    if (m_valid) begin
      chk("down_data_even", ev_if.down_data, m_data);
      chk("down_data_odd", od_if.down_data, m_data);
      chk("parity_even", ev_if.down_parity, even_par(m_data));
      chk("parity_odd", od_if.down_parity, !even_par(m_data));
    end
    if (v && m_ready) begin
      mq.push_back(d);
      if (mq.size() == W) begin
        for (int i = 0; i < W; i++) m_data[i] = mq[i];
        m_valid = 1'b1;
        mq.delete();
        frames++;
        $display("frame %0d: data=0x%02h even_parity=%0d", frames, m_data, even_par(m_data));
      end else if (m_valid && r) begin
        m_valid = 1'b0;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(logic [7:0] f, bit r);
    for (int i = 0; i < W; i++) cycle(1'b1, f[i], r);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_valid = 1'b0;
    m_data  = 8'h00;
  endtask

  initial begin
    logic [7:0] f;
    int idx;

    tbl[0] = '{8'h0D, 8'h0D, 1'b1, 1'b0};
    tbl[1] = '{8'hFF, 8'hFF, 1'b0, 1'b1};
    tbl[2] = '{8'hA5, 8'hA5, 1'b0, 1'b1};
    tbl[3] = '{8'h3C, 8'h3C, 1'b0, 1'b1};
    tbl[4] = '{8'h01, 8'h01, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 1'b1};

    m_valid = 1'b0;
    m_data  = 8'h00;
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    #1;
    chk("rst_down_valid", ev_if.down_valid, 1'b0);
    chk("rst_down_data", ev_if.down_data, 8'h00);
    chk("rst_down_parity", ev_if.down_parity, 1'b0);
    chk("rst_up_ready", ev_if.up_ready, 1'b1);
    chk("rst_odd_valid", od_if.down_valid, 1'b0);

    // Table of known frames, consumer always ready.
    for (int t = 0; t < 6; t++) begin
      send_frame(tbl[t].frame, 1'b1);
      chk("tbl_valid", ev_if.down_valid, 1'b1);
      chk("tbl_data", ev_if.down_data, tbl[t].exp_data);
      chk("tbl_par_even", ev_if.down_parity, tbl[t].exp_even);
      chk("tbl_par_odd", od_if.down_parity, tbl[t].exp_odd);
      cycle(1'b0, 1'b0, 1'b1);
      chk("tbl_valid_one_cycle", ev_if.down_valid, 1'b0);
    end

    // Backpressure: 0xFF held while 0x01 collects; completing bit stalls.
    send_frame(8'hFF, 1'b0);
    f = 8'h01;
    for (int i = 0; i < W - 1; i++) cycle(1'b1, f[i], 1'b0);
    for (int s = 0; s < 3; s++) begin
      cycle(1'b1, f[W-1], 1'b0);
      chk("bp_up_ready_low", ev_if.up_ready, 1'b0);
      chk("bp_hold_data", ev_if.down_data, 8'hFF);
      chk("bp_hold_valid", ev_if.down_valid, 1'b1);
    end
    cycle(1'b1, f[W-1], 1'b1);
    chk("bp_valid_kept", ev_if.down_valid, 1'b1);
    chk("bp_new_data", ev_if.down_data, 8'h01);
    chk("bp_new_parity", ev_if.down_parity, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Drain and complete in the same cycle, no stall.
    send_frame(8'h5A, 1'b0);
    f = 8'hC3;
    for (int i = 0; i < W - 1; i++) cycle(1'b1, f[i], 1'b0);
    cycle(1'b1, f[W-1], 1'b1);
    chk("dc_valid", ev_if.down_valid, 1'b1);
    chk("dc_data", ev_if.down_data, 8'hC3);
    chk("dc_par_even", ev_if.down_parity, 1'b0);
    chk("dc_par_odd", od_if.down_parity, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Reset mid-frame with a held frame: both are dropped.
    send_frame(8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
    do_reset();
    #1;
    chk("mid_rst_valid", ev_if.down_valid, 1'b0);
    chk("mid_rst_data", ev_if.down_data, 8'h00);
    send_frame(8'hA5, 1'b1);
    chk("mid_rst_frame", ev_if.down_data, 8'hA5);
    chk("mid_rst_parity", ev_if.down_parity, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("mid_rst_single", ev_if.down_valid, 1'b0);

    // Random gaps inside a frame.
    f = 8'h3C;
    idx = 0;
    for (int k = 0; k < 200 && idx < W; k++) begin
      bit v;
      v = bit'($urandom_range(0, 1));
      cycle(v, f[idx], 1'b1);
      if (v) idx++;
    end
    chk("gap_bits_sent", idx, W);
    chk("gap_data", ev_if.down_data, 8'h3C);
    chk("gap_parity", ev_if.down_parity, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // Fully random traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 2) != 0));
    end
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1);
    chk("final_empty", ev_if.down_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_parity_framer.md
# serial_parity_framer

Deserialises a 1-bit upstream stream into `DATA_W`-bit frames and computes each frame's parity as the running XOR of its bits. It sits directly downstream of the XOR-gate datapath stage. It turns a serial bit source into parallel words with a parity bit attached, behind a valid/ready handshake. The output is buffered so that serial input can continue at one bit per clock while a completed frame waits for the consumer.

## Interface
- `DATA_W`, default 8: frame width in bits; legal range ≥ 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `up_valid` input 1: upstream bit is valid this cycle.
- `up_data` input 1: serial data bit.
- `up_ready` output 1: block accepts `up_data` this cycle.
- `down_valid` output 1: completed frame available.
- `down_data` output `DATA_W`: frame; first-received bit at bit 0.
- `down_parity` output 1: parity of `down_data` per `PARITY_ODD`.
- `down_ready` input 1: consumer accepts the frame this cycle.

## Operation
- **Transfer rules.** An upstream transfer occurs when `up_valid && up_ready`. A downstream transfer occurs when `down_valid && down_ready`.
- **Collect side.**
  - State: shift register `acc[DATA_W-1:0]`, bit counter `cnt` (0..`DATA_W-1`, width `$clog2(DATA_W)`), running parity `par`.
  - On each accepted bit: `acc[cnt] <= up_data`; `par <= par ^ up_data`; `cnt` increments.
- **Frame completion.** An accepted bit with `cnt == DATA_W-1` completes the frame:
  - Load the output register: `down_data <= {up_data, acc[DATA_W-2:0]}` and `down_parity <= par ^ up_data ^ PARITY_ODD`.
  - Set `down_valid <= 1`.
  - Clear `cnt` and `par` to 0.
  - `cnt` wraps from `DATA_W-1` to 0 only on this event.
- **Output side** (two states, tracked by the `down_valid` flag):
  - EMPTY → FULL on frame completion.
  - FULL → EMPTY on a downstream transfer with no completion in the same cycle.
  - FULL → FULL when a downstream transfer and a completion occur in the same cycle; the new frame replaces the old one.
- **Ready rule.**
  - `up_ready = (cnt != DATA_W-1) || !down_valid || down_ready`.
  - Bits 0..`DATA_W-2` of a frame are always accepted.
  - Only the completing bit is stalled, and only while a held frame is not being drained.
- **Output stability.** While `down_valid && !down_ready`, `down_data` and `down_parity` hold stable.
- **Gaps.** `up_valid` low leaves all state unchanged; gaps anywhere inside a frame are legal.

## Timing
- **Reset values.** `rst` high at a clock edge clears:
  - `cnt`, `par`, `acc` to 0;
  - `down_valid`, `down_data`, `down_parity` to 0.
  - `up_ready` is therefore 1 in the cycle after reset.
- **Reset priority.** Reset overrides any concurrent transfer. A partial frame in progress is discarded, and a held output frame is dropped.
- **Latency.** The completing bit is accepted in cycle N; `down_valid` is high in cycle N+1.
- **Throughput.** Sustained 1 bit/clock, i.e. one frame per `DATA_W` cycles when `down_ready` is held high.
- **Combinational path.** `up_ready` depends combinationally on `down_ready`; there is no other combinational input-to-output path.

## Structure
- **Shared package.** Place the output state enum (EMPTY, FULL) and the parity-mode constants (`PARITY_EVEN = 1'b0`, `PARITY_ODD = 1'b1`) in a shared package.
- **Sub-module.** One sub-module is natural: `serial_parity_accum`, which holds `acc`, `cnt`, `par` and the `last` flag. The top level holds the output register and the handshake logic.

## Test plan
- **Basic frame, even parity.** `DATA_W=8`, `PARITY_ODD=0`, `down_ready=1`. Stream bits 1,0,1,1,0,0,0,0 → `down_data=8'h0D`, `down_parity=1`, `down_valid` high exactly one cycle, one cycle after the 8th bit.
- **Odd parity.** Same stream with `PARITY_ODD=1` → `down_data=8'h0D`, `down_parity=0`. Stream of 8'hFF → `down_parity=1`.
- **Backpressure.** `down_ready=0`, back-to-back bits for frames 8'hFF then 8'h01. Required response:
  - frame 0xFF held stable;
  - `up_ready` drops at the 8th bit of frame 2 and stays low until `down_ready=1`;
  - then 0x01 appears the next cycle, parity 1, with no bit lost.
- **Simultaneous drain and complete.** With `down_valid=1`, assert `down_ready=1` in the same cycle as the completing bit → the old frame is consumed, the new frame is valid next cycle, and `down_valid` never deasserts.
- **Reset mid-frame.** Reset mid-frame after 5 bits, then stream 8'hA5 (LSB first) → exactly one frame, `down_data=8'hA5`, `down_parity=0`.
- **Random gaps.** Random `up_valid` gaps with 8'h3C → same result as a gapless stream: 0x3C, parity 0.
